// File: rtl/pwl_act_simd_if.sv
// Stream bundle for pwl_act_simd: one input beat channel and one output beat channel.
// Handshake: a beat moves when valid && ready at a rising edge; valid never waits on ready.
interface pwl_act_simd_if #(
  parameter int LANES = 2,
  parameter int W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [LANES*W-1:0]   in_x;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_y;
  logic [LANES-1:0]     out_sat;

  modport master (
    output in_valid, in_mode, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_sat
  );

  modport slave (
    input  in_valid, in_mode, in_x, out_ready,
    output in_ready, out_valid, out_y, out_sat
  );
endinterface

// File: rtl/pwl_act_simd.sv
// Multi-lane piecewise-linear tanh/sigmoid in fixed point, 3-stage stallable pipeline.
// Sigmoid reuses the tanh path via sigmoid(x) = tanh(x/2)/2 + 1/2.
module pwl_act_simd #(
  parameter int LANES = 2,
  parameter int W     = 16,
  parameter int FRAC  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  pwl_act_simd_if.slave        bus,
  input  logic                 sat_cnt_clr,
  output logic [31:0]          sat_cnt
);

  localparam real SCALE = real'(1 << FRAC);
  localparam logic signed [W-1:0] M_IN    = W'(int'(0.76159 * SCALE));
  localparam logic signed [W-1:0] M_OUT   = W'(int'(0.11673 * SCALE));
  localparam logic signed [W-1:0] C_POS   = W'(int'(0.64486 * SCALE));
  localparam logic signed [W-1:0] SAT_POS = W'(int'(0.995 * SCALE));
  localparam logic signed [W-1:0] HALF    = W'(int'(0.5 * SCALE));
  localparam logic signed [W-1:0] B1      = W'(1 << FRAC);
  localparam logic signed [W-1:0] B3      = W'(3 << FRAC);
  localparam logic signed [W-1:0] C_NEG   = -C_POS;
  localparam logic signed [W-1:0] SAT_NEG = -SAT_POS;
  localparam logic signed [W-1:0] NEG_B1  = -B1;
  localparam logic signed [W-1:0] NEG_B3  = -B3;

  typedef enum logic [2:0] {SEG_LO, SEG_NEG, SEG_MID, SEG_POS, SEG_HI} seg_t;

  logic w_en;
  logic w_deliver;

  // stage 1: decode
  logic signed [W-1:0] w_x   [LANES];
  logic signed [W-1:0] w_t   [LANES];
  seg_t                w_seg [LANES];
  logic                r_s1_valid;
  logic                r_s1_mode;
  logic signed [W-1:0] r_s1_t   [LANES];
  seg_t                r_s1_seg [LANES];

  // stage 2: multiply-add
  logic signed [W-1:0]   w_m    [LANES];
  logic signed [W-1:0]   w_c    [LANES];
  logic signed [2*W-1:0] w_prod [LANES];
  logic signed [W-1:0]   w_r    [LANES];
  logic [LANES-1:0]      w_sat;
  logic                  r_s2_valid;
  logic                  r_s2_mode;
  logic signed [W-1:0]   r_s2_r [LANES];
  logic [LANES-1:0]      r_s2_sat;

  // stage 3: mode fix-up and output
  logic [LANES*W-1:0]  w_y_flat;
  logic                r_out_valid;
  logic [LANES*W-1:0]  r_out_y;
  logic [LANES-1:0]    r_out_sat;
  logic [31:0]         r_sat_cnt;

  assign w_en      = !r_out_valid || bus.out_ready;
  assign w_deliver = r_out_valid && bus.out_ready;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_x[i] = $signed(bus.in_x[i*W +: W]);
      w_t[i] = bus.in_mode ? (w_x[i] >>> 1) : w_x[i];
      if (w_t[i] < NEG_B3)      w_seg[i] = SEG_LO;
      else if (w_t[i] > B3)     w_seg[i] = SEG_HI;
      else if (w_t[i] < NEG_B1) w_seg[i] = SEG_NEG;
      else if (w_t[i] < B1)     w_seg[i] = SEG_MID;
      else                      w_seg[i] = SEG_POS;
    end
  end

  always_comb begin
    w_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      w_m[i] = '0;
      w_c[i] = '0;
      case (r_s1_seg[i])
        SEG_NEG: begin w_m[i] = M_OUT; w_c[i] = C_NEG; end
        SEG_MID: begin w_m[i] = M_IN;  w_c[i] = '0;    end
        SEG_POS: begin w_m[i] = M_OUT; w_c[i] = C_POS; end
        default: begin w_m[i] = '0;    w_c[i] = '0;    end
      endcase
      // Sign-extend both factors so the low 2W product bits are the signed product.
      w_prod[i] = {{W{w_m[i][W-1]}}, w_m[i]} * {{W{r_s1_t[i][W-1]}}, r_s1_t[i]};
      w_r[i]    = W'(w_prod[i] >>> FRAC) + w_c[i];
      if (r_s1_seg[i] == SEG_LO) begin
        w_r[i]   = SAT_NEG;
        w_sat[i] = 1'b1;
      end else if (r_s1_seg[i] == SEG_HI) begin
        w_r[i]   = SAT_POS;
        w_sat[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_y_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      w_y_flat[i*W +: W] = r_s2_mode ? ((r_s2_r[i] >>> 1) + HALF) : r_s2_r[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_mode   <= 1'b0;
      r_s2_sat    <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_sat   <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_t[i]   <= '0;
        r_s1_seg[i] <= SEG_MID;
        r_s2_r[i]   <= '0;
      end
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_mode   <= bus.in_mode;
      r_s2_valid  <= r_s1_valid;
      r_s2_mode   <= r_s1_mode;
      r_s2_sat    <= w_sat;
      r_out_valid <= r_s2_valid;
      r_out_y     <= w_y_flat;
      r_out_sat   <= r_s2_sat;
      for (int i = 0; i < LANES; i++) begin
        r_s1_t[i]   <= w_t[i];
        r_s1_seg[i] <= w_seg[i];
        r_s2_r[i]   <= w_r[i];
      end
    end
  end

  // Clear beats a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      r_sat_cnt <= '0;
    end else if (w_deliver && (|r_out_sat) && (r_sat_cnt != 32'hFFFF_FFFF)) begin
      r_sat_cnt <= r_sat_cnt + 32'd1;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_sat   = r_out_sat;
  assign sat_cnt       = r_sat_cnt;

endmodule

// File: tb/tb_pwl_act_simd.sv
// Directed bench for pwl_act_simd (LANES=2, W=16, FRAC=11) with hand-computed results.
module tb_pwl_act_simd;
  localparam int LANES = 2;
  localparam int W     = 16;

  typedef struct packed {
    logic        mode;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;
    logic [1:0]  sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_cnt_clr;
  logic [31:0] sat_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  vec_t        stream_v [10];
  logic [33:0] exp_q [$];
  logic [31:0] hold_y;
  logic [33:0] exp_beat;
  int          sent;
  int          got;

  pwl_act_simd_if #(.LANES(LANES), .W(W)) bus ();

  pwl_act_simd #(.LANES(LANES), .W(W), .FRAC(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sat_cnt_clr (sat_cnt_clr),
    .sat_cnt     (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single beat with out_ready=1: checks exact 3-cycle latency and one-cycle delivery.
  task automatic run_one(input string tag, input logic mode, input logic [15:0] x0,
                         input logic [15:0] x1, input logic [15:0] y0, input logic [15:0] y1,
                         input logic [1:0] sat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_x     = {x1, x0};
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    @(negedge clk);
    check({tag, "_early_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_y0"}, 64'(bus.out_y[15:0]), 64'(y0));
    check({tag, "_y1"}, 64'(bus.out_y[31:16]), 64'(y1));
    check({tag, "_sat"}, 64'(bus.out_sat), 64'(sat));
    @(negedge clk);
    check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    stream_v[0] = '{1'b0, 16'd0,          16'd1024,       16'd0,          16'd780,        2'b00};
    stream_v[1] = '{1'b1, 16'd0,          16'(-2048),     16'd1024,       16'd634,        2'b00};
    stream_v[2] = '{1'b0, 16'd4096,       16'(-4096),     16'd1799,       16'(-1799),     2'b00};
    stream_v[3] = '{1'b1, 16'd8192,       16'(-8192),     16'd1923,       16'd124,        2'b00};
    stream_v[4] = '{1'b0, 16'd7000,       16'(-7000),     16'd2038,       16'(-2038),     2'b11};
    stream_v[5] = '{1'b1, 16'd100,        16'(-100),      16'd1043,       16'd1004,       2'b00};
    stream_v[6] = '{1'b0, 16'd2047,       16'(-2049),     16'd1559,       16'(-1561),     2'b00};
    stream_v[7] = '{1'b1, 16'd12288,      16'(-12290),    16'd2043,       16'd5,          2'b10};
    stream_v[8] = '{1'b0, 16'(-6144),     16'd1,          16'(-2038),     16'd0,          2'b00};
    stream_v[9] = '{1'b1, 16'(-1),        16'd32767,      16'd1023,       16'd2043,       2'b10};

    // reset state
    rst           = 1'b1;
    sat_cnt_clr   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_y", 64'(bus.out_y), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;

    // directed single beats
    run_one("tanh_pm1", 1'b0, 16'h0800, 16'hF800, 16'd1560, 16'(-1560), 2'b00);
    check("cnt_after_nonsat", 64'(sat_cnt), 64'd0);
    run_one("tanh_b3", 1'b0, 16'd6144, 16'd6145, 16'd2038, 16'd2038, 2'b10);
    check("cnt_after_b3", 64'(sat_cnt), 64'd1);
    run_one("sig_0_2", 1'b1, 16'd0, 16'd4096, 16'd1024, 16'd1804, 2'b00);
    run_one("sig_neg8", 1'b1, 16'(-16384), 16'd0, 16'd5, 16'd1024, 2'b01);
    run_one("sig_pos8", 1'b1, 16'd16384, 16'(-4096), 16'd2043, 16'd244, 2'b01);
    check("cnt_after_sig", 64'(sat_cnt), 64'd3);

    // 10-beat stream, alternating mode, out_ready low for cycles 6..9
    sent = 0;
    got  = 0;
    hold_y = '0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 6 && cyc < 10);
      #1;
      if (cyc >= 6 && cyc < 10) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        if (cyc == 6) hold_y = bus.out_y;
        else check("stall_y_hold", 64'(bus.out_y), 64'(hold_y));
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_beat = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("stream_beat", 64'({bus.out_sat, bus.out_y}), 64'(exp_beat));
        got++;
      end
      if (sent < 10) begin
        bus.in_valid = 1'b1;
        bus.in_mode  = stream_v[sent].mode;
        bus.in_x     = {stream_v[sent].x1, stream_v[sent].x0};
        if (bus.in_ready) begin
          exp_q.push_back({stream_v[sent].sat, stream_v[sent].y1, stream_v[sent].y0});
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 64'(got), 64'd10);
    check("stream_leftover", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("cnt_after_stream", 64'(sat_cnt), 64'd6);

    // reset with three saturating beats in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_mode  = 1'b0;
      bus.in_x     = {16'd7000, 16'd7000};
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    rst = 1'b1;
    #1;
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_y", 64'(bus.out_y), 64'd0);
    check("flush_sat", 64'(bus.out_sat), 64'd0);
    check("flush_cnt", 64'(sat_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("flush_no_output", 64'(bus.out_valid), 64'd0);
    end

    // clear coincident with a saturating delivery
    run_one("clr_setup", 1'b0, 16'd7000, 16'd0, 16'd2038, 16'd0, 2'b01);
    check("clr_setup_cnt", 64'(sat_cnt), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = 1'b0;
    bus.in_x     = {16'd0, 16'(-7000)};
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    @(negedge clk);
    @(negedge clk);
    check("clr_sat_valid", 64'(bus.out_valid), 64'd1);
    check("clr_sat_flag", 64'(bus.out_sat), 64'd1);
    sat_cnt_clr = 1'b1;
    @(negedge clk);
    sat_cnt_clr = 1'b0;
    check("clr_wins", 64'(sat_cnt), 64'd0);
    check("clr_delivered", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
